// File: rtl/cs_loader.sv
`default_nettype none
// ============================================================================
//  Module      : cs_loader
//  Description : Writable control store. A 2**ADDR_W x DATA_W microword RAM
//                filled from a byte stream (3 bytes per word, LSB first),
//                followed by one XOR checksum byte. The combinational read
//                port returns the NOP word (all zeros) until a load has
//                completed with a good checksum.
//  Revision    : 1.0 - initial release
// ============================================================================
module cs_loader #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 23
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] cs_bits,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int              DEPTH        = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] C_DEPTH      = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] C_LAST_WORD  = C_DEPTH - 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [7:0]        byte0_q, byte0_d;
    logic [7:0]        byte1_q, byte1_d;
    logic [7:0]        csum_q, csum_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              w_accept;
    logic              w_we;
    logic              w_hi_bad;
    logic [23:0]       w_word24;

    // The loader only listens while a load is in progress.
    assign in_ready = (state_q == ST_LOAD) || (state_q == ST_CHECK);
    assign busy     = in_ready;
    assign w_accept = in_valid && in_ready;

    // Word being completed by the current (third) byte.
    assign w_word24 = {in_data, byte1_q, byte0_q};

    // Any set bit above the microword width marks a malformed stream.
    generate
        if (DATA_W < 24) begin : g_hi_check
            assign w_hi_bad = |w_word24[23:DATA_W];
        end else begin : g_no_hi_check
            assign w_hi_bad = 1'b0;
        end
    endgenerate

    // Next-state and datapath update for the loader FSM.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        byte0_d    = byte0_q;
        byte1_d    = byte1_q;
        csum_d     = csum_q;
        words_d    = words_q;
        done_d     = done_q;
        err_d      = err_q;
        w_we       = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d    = ST_LOAD;
                    byte_cnt_d = 2'd0;
                    csum_d     = 8'd0;
                    words_d    = '0;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                end
            end

            ST_LOAD: begin
                if (w_accept) begin
                    csum_d = csum_q ^ in_data;
                    case (byte_cnt_q)
                        2'd0: begin
                            byte0_d    = in_data;
                            byte_cnt_d = 2'd1;
                        end
                        2'd1: begin
                            byte1_d    = in_data;
                            byte_cnt_d = 2'd2;
                        end
                        default: begin
                            byte_cnt_d = 2'd0;
                            if (w_hi_bad) begin
                                state_d = ST_ERR;
                                err_d   = 1'b1;
                            end else begin
                                w_we = 1'b1;
                                if (words_q != C_DEPTH) begin
                                    words_d = words_q + 1'b1;
                                end
                                if (words_q == C_LAST_WORD) begin
                                    state_d = ST_CHECK;
                                end
                            end
                        end
                    endcase
                end
            end

            ST_CHECK: begin
                if (w_accept) begin
                    if (in_data == csum_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Loader state registers; reset returns to IDLE immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= 2'd0;
            byte0_q    <= 8'd0;
            byte1_q    <= 8'd0;
            csum_q     <= 8'd0;
            words_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            byte0_q    <= byte0_d;
            byte1_q    <= byte1_d;
            csum_q     <= csum_d;
            words_q    <= words_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Microword RAM write; contents survive reset, the read gate hides them.
    always_ff @(posedge clk) begin
        if (w_we) begin
            mem_q[words_q[ADDR_W-1:0]] <= w_word24[DATA_W-1:0];
        end
    end

    // Read port returns NOP unless the last load verified.
    assign cs_bits      = done_q ? mem_q[rd_addr] : '0;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_q;

endmodule
`default_nettype wire

// File: tb/tb_cs_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cs_loader
//  Description : Directed self-checking bench for cs_loader.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cs_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [5:0]  rd_addr;
    logic [22:0] cs_bits;
    logic        busy;
    logic        done;
    logic        err;
    logic [6:0]  words_loaded;

    int          checks = 0;
    int          errors = 0;
    int          accepted;
    logic [22:0] img [64];

    always #5 clk = ~clk;

    cs_loader #(.ADDR_W(6), .DATA_W(23)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .rd_addr      (rd_addr),
        .cs_bits      (cs_bits),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    // Byte j (0 = LSB) of image word i as it appears on the stream.
    function automatic logic [7:0] img_byte(input int i, input int j);
        logic [22:0] w;
        w = img[i];
        case (j)
            0:       return w[7:0];
            1:       return w[15:8];
            default: return {1'b0, w[22:16]};
        endcase
    endfunction

    function automatic logic [7:0] img_csum();
        logic [7:0] c;
        c = 8'd0;
        for (int i = 0; i < 64; i++) begin
            for (int j = 0; j < 3; j++) begin
                c = c ^ img_byte(i, j);
            end
        end
        return c;
    endfunction

    task automatic fill_img1();
        for (int i = 0; i < 64; i++) img[i] = 23'(i * 32'h1111);
    endtask

    task automatic fill_img2();
        for (int i = 0; i < 64; i++) img[i] = 23'h7FFFFF - 23'(i);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || err !== 1'b0 || words_loaded !== 7'd0) begin
            errors++;
            $display("FAIL start_entry: busy=%b done=%b err=%b words=%0d want 1 0 0 0",
                     busy, done, err, words_loaded);
        end
    endtask

    // Streams image bytes plus checksum; optional gaps and a stray start pulse.
    task automatic send_stream(input int gap_max, input logic [7:0] csum_xor,
                               input int start_idx, input int max_bytes);
        logic [7:0] b;
        int         g;
        accepted = 0;
        for (int k = 0; k < 193 && k < max_bytes; k++) begin
            if (gap_max > 0) begin
                g = $urandom_range(0, gap_max);
                repeat (g) begin @(posedge clk); #1; end
            end
            b        = (k < 192) ? img_byte(k / 3, k % 3) : (img_csum() ^ csum_xor);
            in_valid = 1'b1;
            in_data  = b;
            start    = (k == start_idx);
            checks++;
            if (in_ready !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL stream_ready byte %0d: in_ready=%b busy=%b want 1 1", k, in_ready, busy);
                in_valid = 1'b0;
                start    = 1'b0;
                return;
            end
            checks++;
            if (done !== 1'b0 || cs_bits !== 23'd0) begin
                errors++;
                $display("FAIL gate_during_load byte %0d: done=%b cs_bits=%h want 0 0", k, done, cs_bits);
            end
            @(posedge clk); #1;
            accepted++;
            in_valid = 1'b0;
            start    = 1'b0;
        end
    endtask

    task automatic check_readback(input string name);
        for (int i = 0; i < 64; i++) begin
            rd_addr = 6'(i);
            #1;
            checks++;
            if (cs_bits !== img[i]) begin
                errors++;
                $display("FAIL %s addr %0d: got %h want %h", name, i, cs_bits, img[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic check_done_state(input string name);
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 ||
            words_loaded !== 7'd64) begin
            errors++;
            $display("FAIL %s: done=%b err=%b busy=%b rdy=%b words=%0d want 1 0 0 0 64",
                     name, done, err, busy, in_ready, words_loaded);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
            words_loaded !== 7'd0 || cs_bits !== 23'd0) begin
            errors++;
            $display("FAIL reset: rdy=%b busy=%b done=%b err=%b words=%0d cs=%h want all 0",
                     in_ready, busy, done, err, words_loaded, cs_bits);
        end
    endtask

    task automatic test_full_load();
        fill_img1();
        do_start();
        send_stream(0, 8'h00, -1, 193);
        checks++;
        if (accepted !== 193) begin
            errors++;
            $display("FAIL full_accepts: got %0d want 193", accepted);
        end
        check_done_state("full_done");
        rd_addr = 6'd5;
        #1;
        checks++;
        if (cs_bits !== 23'h005555) begin
            errors++;
            $display("FAIL full_addr5: got %h want 005555", cs_bits);
        end
        @(posedge clk); #1;
        check_readback("full_readback");
    endtask

    task automatic test_bad_csum();
        do_start();
        send_stream(0, 8'h01, -1, 193);
        checks++;
        if (err !== 1'b1 || done !== 1'b0 || words_loaded !== 7'd64 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_csum: err=%b done=%b words=%0d busy=%b want 1 0 64 0",
                     err, done, words_loaded, busy);
        end
        for (int i = 0; i < 64; i++) begin
            rd_addr = 6'(i);
            #1;
            checks++;
            if (cs_bits !== 23'd0) begin
                errors++;
                $display("FAIL bad_csum_gate addr %0d: got %h want 0", i, cs_bits);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_format_err();
        do_start();
        send_stream(0, 8'h00, -1, 32);
        in_valid = 1'b1;
        in_data  = 8'h80;
        checks++;
        if (err !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL fmt_pre: err=%b rdy=%b want 0 1", err, in_ready);
        end
        @(posedge clk); #1;
        in_data = 8'h11;
        checks++;
        if (err !== 1'b1 || done !== 1'b0 || words_loaded !== 7'd10 || busy !== 1'b0) begin
            errors++;
            $display("FAIL fmt_err: err=%b done=%b words=%0d busy=%b want 1 0 10 0",
                     err, done, words_loaded, busy);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fmt_no_accept: in_ready=%b want 0", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (err !== 1'b1 || words_loaded !== 7'd10) begin
            errors++;
            $display("FAIL fmt_hold: err=%b words=%0d want 1 10", err, words_loaded);
        end
    endtask

    task automatic test_gaps();
        fill_img1();
        do_start();
        send_stream(5, 8'h00, 50, 193);
        checks++;
        if (accepted !== 193) begin
            errors++;
            $display("FAIL gaps_accepts: got %0d want 193", accepted);
        end
        check_done_state("gaps_done");
        check_readback("gaps_readback");
    endtask

    task automatic test_reset_mid();
        do_start();
        send_stream(0, 8'h00, -1, 100);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
            words_loaded !== 7'd0 || cs_bits !== 23'd0) begin
            errors++;
            $display("FAIL reset_mid: rdy=%b busy=%b done=%b err=%b words=%0d cs=%h want all 0",
                     in_ready, busy, done, err, words_loaded, cs_bits);
        end
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b rdy=%b want 0 0", busy, in_ready);
        end
        do_start();
        send_stream(0, 8'h00, -1, 193);
        check_done_state("reset_reload_done");
        check_readback("reset_readback");
    endtask

    task automatic test_back_to_back();
        fill_img2();
        do_start();
        send_stream(3, 8'h00, -1, 193);
        check_done_state("reload_done");
        rd_addr = 6'd0;
        #1;
        checks++;
        if (cs_bits !== 23'h7FFFFF) begin
            errors++;
            $display("FAIL reload_addr0: got %h want 7fffff", cs_bits);
        end
        rd_addr = 6'd31;
        #1;
        checks++;
        if (cs_bits !== 23'h7FFFE0) begin
            errors++;
            $display("FAIL reload_addr31: got %h want 7fffe0", cs_bits);
        end
        rd_addr = 6'd63;
        #1;
        checks++;
        if (cs_bits !== 23'h7FFFC0) begin
            errors++;
            $display("FAIL reload_addr63: got %h want 7fffc0", cs_bits);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        rd_addr  = 6'd0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_full_load();
        test_bad_csum();
        test_format_err();
        test_gaps();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
